// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - job controller for a weight-stationary MAC array
// Optional MAC_CTRL_BIAS_EN adds a per-job bias input driven onto ci while computing.
module mac_ctrl #(
  parameter int DW       = 8,
  parameter int CW       = 19,
  parameter int ROW      = 7,
  parameter int COLUMN   = 7,
  parameter int PIPE_LAT = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          cfg_len,
  input  logic                 w_s_valid,
  output logic                 w_s_ready,
  input  logic [COLUMN*DW-1:0] w_s_data,
  input  logic                 x_s_valid,
  output logic                 x_s_ready,
  input  logic [ROW*DW-1:0]    x_s_data,
  output logic [ROW*DW-1:0]    mac_m_data,
  output logic [COLUMN*DW-1:0] w,
  output logic [ROW-1:0]       w_en,
  output logic [COLUMN*CW-1:0] ci,
  input  logic [COLUMN*CW-1:0] mac_s_data,
  output logic                 o_valid,
  output logic                 o_first,
  output logic                 o_last,
  output logic [COLUMN*CW-1:0] o_data,
  output logic                 busy,
  output logic                 done
`ifdef MAC_CTRL_BIAS_EN
  ,
  input  logic [COLUMN*CW-1:0] bias
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD_W  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  localparam int RCW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [RCW-1:0] ROW_LAST = RCW'(ROW - 1);

  logic [1:0]          state;
  logic [15:0]         len_q;
  logic [15:0]         x_cnt;
  logic [15:0]         o_cnt;
  logic [RCW-1:0]      row_cnt;
  logic [PIPE_LAT-1:0] vsr;

  logic w_hs;
  logic x_hs;
  logic start_ok;
  logic vsr_empty;

  assign w_hs      = (state == LOAD_W) && w_s_valid;
  assign x_hs      = (state == COMPUTE) && x_s_valid;
  assign start_ok  = (state == IDLE) && start;
  assign vsr_empty = (vsr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      x_cnt   <= '0;
      o_cnt   <= '0;
      row_cnt <= '0;
      vsr     <= '0;
    end else begin
      // The array never stalls, so the tracker shifts every cycle.
      vsr <= (vsr << 1) | PIPE_LAT'(x_hs);
      if (o_valid) begin
        o_cnt <= o_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q   <= cfg_len;
            row_cnt <= '0;
            x_cnt   <= '0;
            o_cnt   <= '0;
            state   <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_hs) begin
            row_cnt <= row_cnt + RCW'(1);
            if (row_cnt == ROW_LAST) begin
              state <= (len_q == 16'd0) ? DRAIN : COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (x_hs) begin
            x_cnt <= x_cnt + 16'd1;
            if (x_cnt + 16'd1 == len_q) begin
              state <= DRAIN;
            end
          end
        end
        default: begin
          if (vsr_empty) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef MAC_CTRL_BIAS_EN
  logic [COLUMN*CW-1:0] bias_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q <= '0;
    end else if (start_ok) begin
      bias_q <= bias;
    end
  end

  assign ci = ((state == COMPUTE) || (state == DRAIN)) ? bias_q : '0;
`else
  assign ci = '0;
`endif

  assign w_s_ready  = (state == LOAD_W);
  assign x_s_ready  = (state == COMPUTE);
  assign w          = w_hs ? w_s_data : '0;
  assign w_en       = w_hs ? (ROW'(1) << row_cnt) : '0;
  assign mac_m_data = x_hs ? x_s_data : '0;

  assign o_valid = vsr[PIPE_LAT-1];
  assign o_first = o_valid && (o_cnt == 16'd0);
  assign o_last  = o_valid && (o_cnt == len_q - 16'd1);
  // Result data is a pass-through, held at 0 only while reset is asserted.
  assign o_data  = rst_n ? mac_s_data : '0;

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && vsr_empty;

endmodule

// File: tb/tb_mac_ctrl.sv
// tb/tb_mac_ctrl.sv - randomized self-checking bench for mac_ctrl
// Set MAC_CTRL_BIAS_EN to also exercise the bias input.
module tb_mac_ctrl;

  localparam int DW       = 8;
  localparam int CW       = 19;
  localparam int ROW      = 7;
  localparam int COLUMN   = 7;
  localparam int PIPE_LAT = 7;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [15:0]          cfg_len;
  logic                 w_s_valid;
  logic                 w_s_ready;
  logic [COLUMN*DW-1:0] w_s_data;
  logic                 x_s_valid;
  logic                 x_s_ready;
  logic [ROW*DW-1:0]    x_s_data;
  logic [ROW*DW-1:0]    mac_m_data;
  logic [COLUMN*DW-1:0] w;
  logic [ROW-1:0]       w_en;
  logic [COLUMN*CW-1:0] ci;
  logic [COLUMN*CW-1:0] mac_s_data;
  logic                 o_valid;
  logic                 o_first;
  logic                 o_last;
  logic [COLUMN*CW-1:0] o_data;
  logic                 busy;
  logic                 done;
`ifdef MAC_CTRL_BIAS_EN
  logic [COLUMN*CW-1:0] bias;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int jobs_exp = 0;

  mac_ctrl #(
    .DW(DW), .CW(CW), .ROW(ROW), .COLUMN(COLUMN), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .w_s_valid(w_s_valid), .w_s_ready(w_s_ready), .w_s_data(w_s_data),
    .x_s_valid(x_s_valid), .x_s_ready(x_s_ready), .x_s_data(x_s_data),
    .mac_m_data(mac_m_data), .w(w), .w_en(w_en), .ci(ci),
    .mac_s_data(mac_s_data), .o_valid(o_valid), .o_first(o_first),
    .o_last(o_last), .o_data(o_data), .busy(busy), .done(done)
`ifdef MAC_CTRL_BIAS_EN
    , .bias(bias)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
  end

  function automatic logic [COLUMN*CW-1:0] rand_wide();
    logic [COLUMN*CW-1:0] r;
    for (int i = 0; i < COLUMN*CW; i++) r[i] = 1'($urandom_range(1));
    return r;
  endfunction

  task automatic drive_random_data();
    logic [COLUMN*CW-1:0] t;
    t = rand_wide();
    w_s_data = t[COLUMN*DW-1:0];
    t = rand_wide();
    x_s_data = t[ROW*DW-1:0];
    mac_s_data = rand_wide();
  endtask

  // One job: the model tracks beats seen on each stream and the cycles at
  // which results are due, and derives every expected output from those.
  task automatic run_job(input int len, input int w_gap, input int x_gap,
                         input bit noise, input bit start_at_done,
                         input logic [COLUMN*CW-1:0] b);
    int cyc = 0;
    int w_seen = 0;
    int x_seen = 0;
    int out_seen = 0;
    int exp_q[$];
    int done_cyc = -1;
    bit fin = 0;
    int budget;
    bit whs, xhs, e_ov, e_wr, e_xr;
    logic [6:0] e_ctl, got_ctl;
    logic [ROW-1:0] e_wen;
    logic [COLUMN*DW-1:0] e_w;
    logic [ROW*DW-1:0] e_x;
    logic [COLUMN*CW-1:0] e_bias, e_ci;
`ifdef MAC_CTRL_BIAS_EN
    e_bias = b;
`else
    e_bias = '0;
`endif
    budget = 4 * (len + ROW) + 4 * PIPE_LAT + 20;
    start = 1'b1;
    cfg_len = len[15:0];
`ifdef MAC_CTRL_BIAS_EN
    bias = b;
`endif
    drive_random_data();
    w_s_valid = 1'($urandom_range(1));
    x_s_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, w_s_ready, x_s_ready, o_valid, done, |w_en, |mac_m_data} !== 7'b0)
      begin errors++; $display("FAIL idle_before_start got=%b exp=0",
        {busy, w_s_ready, x_s_ready, o_valid, done, |w_en, |mac_m_data}); end
    jobs_exp++;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < budget) begin
      drive_random_data();
`ifdef MAC_CTRL_BIAS_EN
      bias = rand_wide();
`endif
      w_s_valid = ($urandom_range(99) >= w_gap);
      x_s_valid = ($urandom_range(99) >= x_gap);
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (start_at_done && cyc == done_cyc) start = 1'b1;
      cfg_len = 16'($urandom);
      e_wr = (w_seen < ROW);
      e_xr = (w_seen == ROW) && (x_seen < len);
      whs = e_wr && w_s_valid;
      xhs = e_xr && x_s_valid;
      e_ov = (exp_q.size() > 0) && (exp_q[0] == cyc);
      e_ctl = {e_wr, e_xr, e_ov, e_ov && (out_seen == 0), e_ov && (out_seen == len - 1),
               1'b1, (cyc == done_cyc)};
      e_wen = whs ? (ROW'(1) << w_seen) : '0;
      e_w = whs ? w_s_data : '0;
      e_x = xhs ? x_s_data : '0;
      e_ci = (w_seen == ROW) ? e_bias : '0;
      @(negedge clk);
      got_ctl = {w_s_ready, x_s_ready, o_valid, o_first, o_last, busy, done};
      checks++;
      if (got_ctl !== e_ctl) begin errors++;
        $display("FAIL ctl len=%0d cyc=%0d got=%b exp=%b (wr,xr,ov,first,last,busy,done)",
                 len, cyc, got_ctl, e_ctl); end
      checks++;
      if (w_en !== e_wen) begin errors++;
        $display("FAIL w_en cyc=%0d got=%h exp=%h", cyc, w_en, e_wen); end
      checks++;
      if (w !== e_w) begin errors++;
        $display("FAIL w cyc=%0d got=%h exp=%h", cyc, w, e_w); end
      checks++;
      if (mac_m_data !== e_x) begin errors++;
        $display("FAIL mac_m_data cyc=%0d got=%h exp=%h", cyc, mac_m_data, e_x); end
      checks++;
      if (o_data !== mac_s_data) begin errors++;
        $display("FAIL o_data cyc=%0d got=%h exp=%h", cyc, o_data, mac_s_data); end
      checks++;
      if (ci !== e_ci) begin errors++;
        $display("FAIL ci cyc=%0d got=%h exp=%h", cyc, ci, e_ci); end
      if (whs) begin
        w_seen++;
        if (w_seen == ROW && len == 0) done_cyc = cyc + 1;
      end
      if (xhs) begin
        x_seen++;
        exp_q.push_back(cyc + PIPE_LAT);
        if (x_seen == len) done_cyc = cyc + PIPE_LAT + 1;
      end
      if (e_ov) begin
        void'(exp_q.pop_front());
        out_seen++;
      end
      if (cyc == done_cyc) fin = 1;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!fin) begin errors++;
      $display("FAIL job_timeout len=%0d got=%0d cycles exp=done", len, cyc); end
    start = 1'b0;
    w_s_valid = 1'b0;
    x_s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, o_valid, |ci} !== 4'b0) begin errors++;
      $display("FAIL idle_after_job got=%b exp=0000", {busy, done, o_valid, |ci}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    cfg_len = 16'd0;
    w_s_valid = 1'b0;
    x_s_valid = 1'b0;
    drive_random_data();
`ifdef MAC_CTRL_BIAS_EN
    bias = '0;
`endif
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    cfg_len = 16'd5;
    w_s_valid = 1'b1;
    x_s_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({w_s_ready, x_s_ready, o_valid, o_first, o_last, busy, done} !== 7'b0 ||
        w_en !== '0 || w !== '0 || mac_m_data !== '0 || ci !== '0 || o_data !== '0)
      begin errors++; $display("FAIL reset_outputs got=%b exp=0",
        {w_s_ready, x_s_ready, o_valid, o_first, o_last, busy, done}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    w_s_valid = 1'b0;
    x_s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, w_s_ready, x_s_ready, done} !== 4'b0) begin errors++;
      $display("FAIL post_reset_idle got=%b exp=0000", {busy, w_s_ready, x_s_ready, done}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    start = 1'b1;
    cfg_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    w_s_valid = 1'b1;
    repeat (ROW) begin @(posedge clk); #1; end
    w_s_valid = 1'b0;
    x_s_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (x_s_ready !== 1'b1) begin errors++;
      $display("FAIL abort_in_compute got=%b exp=1", x_s_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({w_s_ready, x_s_ready, o_valid, o_first, o_last, busy, done} !== 7'b0 ||
        w_en !== '0 || w !== '0 || mac_m_data !== '0 || ci !== '0 || o_data !== '0)
      begin errors++; $display("FAIL abort_outputs got=%b exp=0",
        {w_s_ready, x_s_ready, o_valid, o_first, o_last, busy, done}); end
    x_s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({o_valid, done, busy} !== 3'b0) begin errors++;
        $display("FAIL abort_quiet cyc=%0d got=%b exp=000", i, {o_valid, done, busy}); end
      @(posedge clk); #1;
    end
    run_job(1, 0, 0, 0, 0, rand_wide());
  endtask

  task automatic test_job_count();
    checks++;
    if (done_cnt !== jobs_exp) begin errors++;
      $display("FAIL job_count got=%0d exp=%0d", done_cnt, jobs_exp); end
  endtask

  initial begin
    test_reset();
    run_job(3, 0, 0, 0, 0, '0);                          // basic job
    run_job(2, 0, 60, 0, 0, '0);                         // bubbles
    run_job(0, 30, 0, 0, 0, '0);                         // zero length
    run_job(5, 20, 20, 1, 1, '0);                        // start noise and start on done
    run_job(4, 0, 0, 0, 0, {COLUMN{CW'(5)}});            // bias of 5
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(1, 20), $urandom_range(0, 50), $urandom_range(0, 50),
              1'($urandom_range(1)), 1'($urandom_range(1)), rand_wide());
    run_job(1, 0, 0, 0, 1, '0);                          // single vector
    test_reset_abort();
    run_job(65535, 0, 0, 0, 0, '0);                      // maximum length
    test_job_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, activation/weight element width.
REQ-002 SHALL have parameter CW, default 19, partial-sum width per column.
REQ-003 SHALL have parameter ROW, default 7, number of array rows.
REQ-004 SHALL have parameter COLUMN, default 7, number of array columns.
REQ-005 SHALL have parameter PIPE_LAT, default 7, cycles from an activation vector entering the array to its result at mac_s_data.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle job request.
REQ-009 SHALL have port cfg_len, input, 16, number of activation vectors in the job.
REQ-010 SHALL have ports w_s_valid (input, 1), w_s_ready (output, 1) and w_s_data (input, COLUMN*DW), the weight-row stream.
REQ-011 SHALL have ports x_s_valid (input, 1), x_s_ready (output, 1) and x_s_data (input, ROW*DW), the activation stream.
REQ-012 SHALL have array-drive outputs mac_m_data (ROW*DW), w (COLUMN*DW), w_en (ROW) and ci (COLUMN*CW).
REQ-013 SHALL have port mac_s_data, input, COLUMN*CW, array result.
REQ-014 SHALL have outputs o_valid, o_first and o_last (1 each) and o_data (COLUMN*CW).
REQ-015 SHALL have outputs busy (1) and done (1, one-cycle pulse).

Function
REQ-016 SHALL implement a four-state FSM: IDLE, LOAD_W, COMPUTE, DRAIN.
REQ-017 IDLE: on start=1, latch cfg_len and move to LOAD_W; the row counter clears to 0.
REQ-018 LOAD_W: w_s_ready=1; each w handshake drives w=w_s_data and w_en one-hot at the row-counter bit in the same cycle, then increments the row counter.
REQ-019 LOAD_W: after handshake ROW-1, go to COMPUTE, or to DRAIN when the latched length is 0.
REQ-020 Outside a w handshake, w_en SHALL be 0 and w SHALL be 0.
REQ-021 COMPUTE: x_s_ready=1; on an x handshake, mac_m_data=x_s_data and the 16-bit x counter increments; with no handshake, mac_m_data=0.
REQ-022 COMPUTE: go to DRAIN on the cycle of the handshake that makes the x counter equal the latched length.
REQ-023 A PIPE_LAT-deep valid shift register SHALL track each x handshake; o_valid=1 exactly PIPE_LAT cycles after that handshake.
REQ-024 Input bubbles SHALL propagate as o_valid=0 gaps, and the array is never stalled.
REQ-025 o_data SHALL be mac_s_data, passed through combinationally.
REQ-026 o_first=1 with the first o_valid of a job; o_last=1 with the cfg_len-th o_valid; both fall in the same cycle when cfg_len=1.
REQ-027 DRAIN: when the valid shift register is empty, pulse done for one cycle and return to IDLE in the same transition.
REQ-028 busy=1 in every state except IDLE.
REQ-029 start SHALL be ignored when not in IDLE.
REQ-030 A start coinciding with the done cycle SHALL be ignored.
REQ-031 The output counter SHALL be 16 bits, and cfg_len=65535 SHALL complete without wrap.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, clear all counters and the valid shift register, and drive every output to 0, including w_en, ready signals, o_valid, done and busy.
REQ-033 Reset mid-job SHALL abandon the job with no done pulse; after release the block waits in IDLE for a new start.

Configuration
REQ-034 With macro MAC_CTRL_BIAS_EN defined, the block SHALL add input bias (COLUMN*CW), latch it on an accepted start, and drive ci with the latched value throughout COMPUTE and DRAIN, with ci=0 elsewhere.
REQ-035 Without MAC_CTRL_BIAS_EN, the bias port SHALL be absent and ci SHALL be tied to 0.

Verification (ROW=7, COLUMN=7, PIPE_LAT=7)
REQ-036 Basic job: start with cfg_len=3, 7 back-to-back w beats, 3 back-to-back x beats at cycles t..t+2 -> w_en walks 0x01 through 0x40; o_valid at t+7..t+9 with o_first at t+7 and o_last at t+9; done once; busy drops.
REQ-037 Bubble: cfg_len=2, x beats at t and t+3 -> o_valid only at t+7 and t+10; o_last at t+10.
REQ-038 Zero length: cfg_len=0 -> after 7 w beats, x_s_ready never rises, o_valid never rises, done pulses, FSM returns to IDLE.
REQ-039 Reset abort: assert rst_n=0 during COMPUTE after 1 of 4 x beats -> all outputs 0 at once; no done; a new start with cfg_len=1 completes normally.
REQ-040 Start during busy, and start coinciding with done -> both ignored; the job count equals the number of accepted starts.
REQ-041 With MAC_CTRL_BIAS_EN: bias=all 5 at start -> ci=5 per column during COMPUTE and DRAIN; ci=0 in IDLE.
